// File: rtl/clock_control.sv
// Run/step/breakpoint controller that produces the datapath clock enable.
// Button and switches are synchronized, and the step button is debounced.
module clock_control #(
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  i_oszClk,
   input  logic                  i_reset,
   input  logic                  i_btnStep,
   input  logic                  i_swInstrNCycle,
   input  logic                  i_swStepNRun,
   input  logic                  i_swEnableBreakpoint,
   input  logic [ADDR_WIDTH-1:0] i_breakpointAddress,
   input  logic [ADDR_WIDTH-1:0] i_nextPc,
   input  logic                  i_instrDone,
   output logic                  o_cpuClkEn,
   output logic                  o_halted,
   output logic                  o_breakHit
);

   localparam int CntW =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax =
      CntW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      HALT, CYCLE, INSTR, RUN, BREAK
   } state_t;

   logic [3:0]      syncA;
   logic [3:0]      syncB;
   logic            btnSync;
   logic            instrNCycle;
   logic            stepNRun;
   logic            bpEnable;
   logic [CntW-1:0] debCnt;
   logic            btnDeb;
   logic            btnDebPrev;
   logic            stepPress;
   logic            stepPrev;
   logic            suppress;
   logic            instrEnd;
   logic            bpMatch;
   state_t          state;
   state_t          nextState;

   assign {bpEnable, stepNRun, instrNCycle, btnSync} = syncB;

   always_ff @(posedge i_oszClk) begin
      if (i_reset) begin
         syncA <= '0;
         syncB <= '0;
      end else begin
         syncA <= {i_swEnableBreakpoint, i_swStepNRun,
                   i_swInstrNCycle, i_btnStep};
         syncB <= syncA;
      end
   end

   // Any bounce back to the current level restarts the stability count.
   always_ff @(posedge i_oszClk) begin
      if (i_reset) begin
         debCnt     <= '0;
         btnDeb     <= 1'b0;
         btnDebPrev <= 1'b0;
      end else begin
         btnDebPrev <= btnDeb;
         if (btnSync == btnDeb) begin
            debCnt <= '0;
         end else if (debCnt == CntMax) begin
            btnDeb <= btnSync;
            debCnt <= '0;
         end else begin
            debCnt <= debCnt + 1'b1;
         end
      end
   end

   assign stepPress = btnDeb & ~btnDebPrev;
   assign instrEnd  = o_cpuClkEn & i_instrDone;
   assign bpMatch   = instrEnd & bpEnable & ~suppress &
                      (i_nextPc == i_breakpointAddress);

   always_comb begin
      nextState = state;
      unique case (state)
         HALT: begin
            if (!stepNRun)
               nextState = RUN;
            else if (stepPress)
               nextState = instrNCycle ? INSTR : CYCLE;
         end
         CYCLE:
            nextState = bpMatch ? BREAK : HALT;
         INSTR: begin
            if (instrEnd)
               nextState = bpMatch ? BREAK : HALT;
         end
         RUN: begin
            if (bpMatch)
               nextState = BREAK;
            else if (stepNRun)
               nextState = HALT;
         end
         BREAK: begin
            if (stepPress) begin
               if (!stepNRun)
                  nextState = RUN;
               else
                  nextState = instrNCycle ? INSTR : CYCLE;
            end else if (stepNRun != stepPrev) begin
               nextState = HALT;
            end
         end
         default:
            nextState = HALT;
      endcase
   end

   // Leaving BREAK masks the breakpoint until one instruction retires.
   always_ff @(posedge i_oszClk) begin
      if (i_reset) begin
         state      <= HALT;
         o_cpuClkEn <= 1'b0;
         o_halted   <= 1'b1;
         o_breakHit <= 1'b0;
         suppress   <= 1'b0;
         stepPrev   <= 1'b0;
      end else begin
         state      <= nextState;
         o_cpuClkEn <= nextState inside {CYCLE, INSTR, RUN};
         o_halted   <= nextState inside {HALT, BREAK};
         o_breakHit <= (nextState == BREAK);
         stepPrev   <= stepNRun;
         if (state == BREAK && nextState != BREAK)
            suppress <= 1'b1;
         else if (instrEnd)
            suppress <= 1'b0;
      end
   end

endmodule

// File: tb/tb_clock_control.sv
// Bench for clock_control: vector table, directed corner sequences,
// and a randomized run against a behavioural model.
module tb_clock_control;

   localparam int DEB = 4;
   localparam int AW  = 16;

   localparam int M_HALT = 0;
   localparam int M_ONE  = 1;
   localparam int M_INS  = 2;
   localparam int M_RUN  = 3;
   localparam int M_BRK  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          btn = 1'b0;
   logic          swI = 1'b0;
   logic          swS = 1'b1;
   logic          swB = 1'b0;
   logic [AW-1:0] bpAddr = '0;
   logic [AW-1:0] nextPc = '0;
   logic          instrDone = 1'b0;
   logic          o_cpuClkEn;
   logic          o_halted;
   logic          o_breakHit;

   int total = 0;
   int bad = 0;

   // Stand-in datapath: 3 enabled cycles per instruction, 8-bit PC.
   logic [7:0] pc = 8'h00;
   int         phase = 0;
   bit         freeze = 1'b0;
   bit         randDp = 1'b0;

   // Model state: what the controller should be doing.
   logic [3:0]     m1 = '0;
   logic [3:0]     m2 = '0;
   logic [DEB-1:0] hist = '0;
   logic           deb = 1'b0;
   logic           debOld = 1'b0;
   logic           stepPrev = 1'b0;
   logic           sup = 1'b0;
   logic           brk = 1'b0;
   int             mode = M_HALT;

   typedef struct {
      logic [4:0] in;
      logic [2:0] exp;
   } vec_t;

   vec_t tbl[15];

   clock_control #(
      .DEBOUNCE_CYCLES(DEB),
      .ADDR_WIDTH(AW)
   ) dut (
      .i_oszClk(clk),
      .i_reset(rst),
      .i_btnStep(btn),
      .i_swInstrNCycle(swI),
      .i_swStepNRun(swS),
      .i_swEnableBreakpoint(swB),
      .i_breakpointAddress(bpAddr),
      .i_nextPc(nextPc),
      .i_instrDone(instrDone),
      .o_cpuClkEn(o_cpuClkEn),
      .o_halted(o_halted),
      .o_breakHit(o_breakHit)
   );

   always #5 clk = ~clk;

   task automatic check(string name, logic [31:0] act,
                        logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic timedOut(string name);
      total++;
      bad++;
      $display("FAIL %s: got no event want event", name);
   endtask

   function automatic logic mEn();
      return mode == M_ONE || mode == M_INS || mode == M_RUN;
   endfunction

   task automatic driveDp();
      if (randDp) begin
         instrDone = ($urandom % 3) == 0;
         nextPc    = AW'($urandom % 4);
      end else begin
         instrDone = !freeze && phase == 2;
         nextPc    = {8'h00, 8'(pc + 8'h01)};
      end
   endtask

   task automatic cpuAdvance();
      if (!randDp && !freeze && mEn()) begin
         if (phase == 2) begin
            phase = 0;
            pc    = pc + 8'h01;
         end else begin
            phase++;
         end
      end
   endtask

   task automatic modelStep();
      logic press, en, bp, stepMode, instrMode, chg;
      int   nm;
      if (rst) begin
         m1 = '0; m2 = '0; hist = '0;
         deb = 0; debOld = 0; stepPrev = 0;
         sup = 0; brk = 0; mode = M_HALT;
         return;
      end
      press     = deb && !debOld;
      en        = mEn();
      stepMode  = m2[2];
      instrMode = m2[1];
      chg       = stepMode != stepPrev;
      bp = en && instrDone && m2[3] && !sup &&
           nextPc == bpAddr;
      nm = mode;
      case (mode)
         M_HALT:
            if (!stepMode) nm = M_RUN;
            else if (press) nm = instrMode ? M_INS : M_ONE;
         M_ONE: nm = bp ? M_BRK : M_HALT;
         M_INS: if (instrDone) nm = bp ? M_BRK : M_HALT;
         M_RUN:
            if (bp) nm = M_BRK;
            else if (stepMode) nm = M_HALT;
         default:
            if (press)
               nm = !stepMode ? M_RUN :
                    (instrMode ? M_INS : M_ONE);
            else if (chg) nm = M_HALT;
      endcase
      if (mode == M_BRK && nm != M_BRK) sup = 1;
      else if (en && instrDone) sup = 0;
      brk  = nm == M_BRK;
      mode = nm;
      // Debounced level flips after DEB straight samples of the other level.
      hist   = {hist[DEB-2:0], m2[0]};
      debOld = deb;
      if (hist == {DEB{~deb}}) deb = ~deb;
      stepPrev = m2[2];
      m2 = m1;
      m1 = {swB, swS, swI, btn};
   endtask

   task automatic tick();
      @(posedge clk);
      cpuAdvance();
      modelStep();
      #1;
      check("model", {o_cpuClkEn, o_halted, o_breakHit},
            {mEn(), ~mEn(), brk});
      driveDp();
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int   cnt, first;
      bit   found;
      logic preEn, preDone;
      logic [AW-1:0] prePc;
      logic [6:0] rstEn;

      // in = {rst, btn, swI, swS, swB}; exp = {en, halted, breakHit}.
      // After reset the synchronizers read run mode for two cycles.
      tbl[0]  = '{5'b10010, 3'b010};
      tbl[1]  = '{5'b10010, 3'b010};
      tbl[2]  = '{5'b00010, 3'b100};
      tbl[3]  = '{5'b00010, 3'b100};
      tbl[4]  = '{5'b00010, 3'b010};
      tbl[5]  = '{5'b00010, 3'b010};
      tbl[6]  = '{5'b01010, 3'b010};
      tbl[7]  = '{5'b01010, 3'b010};
      tbl[8]  = '{5'b01010, 3'b010};
      tbl[9]  = '{5'b01010, 3'b010};
      tbl[10] = '{5'b01010, 3'b010};
      tbl[11] = '{5'b01010, 3'b010};
      tbl[12] = '{5'b01010, 3'b100};
      tbl[13] = '{5'b01010, 3'b010};
      tbl[14] = '{5'b01010, 3'b010};

      freeze = 1;
      driveDp();
      for (int i = 0; i < 15; i++) begin
         {rst, btn, swI, swS, swB} = tbl[i].in;
         tick();
         check($sformatf("vec%0d", i),
               {o_cpuClkEn, o_halted, o_breakHit}, tbl[i].exp);
      end
      btn = 0;
      ticks(10);

      // Bouncy press in cycle-step mode.
      btn = 1; tick();
      btn = 0; tick();
      btn = 1;
      cnt = 0; first = 0;
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (o_cpuClkEn) begin
            cnt++;
            if (first == 0) first = n;
         end
      end
      check("bounce_pulses", cnt, 1);
      check("bounce_latency", first, 7);
      check("bounce_halted", o_halted, 1);
      btn = 0;
      ticks(10);

      // Instruction step: three enabled cycles.
      swI = 1; freeze = 0; phase = 0;
      driveDp();
      ticks(4);
      btn = 1;
      cnt = 0;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (o_cpuClkEn) cnt++;
      end
      check("instr_cycles", cnt, 3);
      check("instr_halted", o_halted, 1);
      btn = 0;
      ticks(10);

      // Free run into the breakpoint.
      swB = 1; bpAddr = 16'h00ff; pc = 8'hf0; phase = 0;
      driveDp();
      swS = 0;
      found = 0; prePc = '0; preDone = 0;
      for (int n = 0; n < 200 && !found; n++) begin
         preEn = o_cpuClkEn; preDone = instrDone; prePc = nextPc;
         tick();
         if (preEn && !o_cpuClkEn) found = 1;
      end
      if (!found) timedOut("bp_stop");
      check("bp_pc", prePc, 16'h00ff);
      check("bp_done", preDone, 1);
      check("bp_hit", o_breakHit, 1);
      check("bp_halted", o_halted, 1);

      // Resume with the breakpoint instruction pending.
      pc = 8'hfe; phase = 2;
      driveDp();
      btn = 1;
      found = 0;
      for (int n = 0; n < 20 && !found; n++) begin
         tick();
         if (o_cpuClkEn) found = 1;
      end
      if (!found) timedOut("resume_start");
      check("resume_hit_clr", o_breakHit, 0);
      tick();
      check("resume_no_rebreak",
            {o_cpuClkEn, o_breakHit}, 2'b10);
      btn = 0;
      found = 0; prePc = '0;
      for (int n = 0; n < 1000 && !found; n++) begin
         preEn = o_cpuClkEn; prePc = nextPc;
         tick();
         if (preEn && !o_cpuClkEn) found = 1;
      end
      if (!found) timedOut("bp_again");
      check("bp_again_pc", prePc, 16'h00ff);
      check("bp_again_hit", o_breakHit, 1);

      // Breakpoint disabled, then step-mode switch stops the run.
      swB = 0; pc = 8'hfe; phase = 0;
      driveDp();
      btn = 1;
      ticks(12);
      btn = 0;
      ticks(30);
      check("nobp_run", {o_cpuClkEn, o_breakHit}, 2'b10);
      swS = 1;
      tick();
      check("sw_t1", o_cpuClkEn, 1);
      tick();
      check("sw_t2", o_cpuClkEn, 1);
      tick();
      check("sw_t3",
            {o_cpuClkEn, o_halted, o_breakHit}, 3'b010);

      // Reset in the middle of an instruction with the button held.
      swI = 1; freeze = 1;
      driveDp();
      ticks(4);
      btn = 1;
      found = 0;
      for (int n = 0; n < 20 && !found; n++) begin
         tick();
         if (o_cpuClkEn) found = 1;
      end
      if (!found) timedOut("rst_instr_start");
      ticks(3);
      check("rst_instr_busy", o_cpuClkEn, 1);
      rst = 1;
      tick();
      check("rst_outputs",
            {o_cpuClkEn, o_halted, o_breakHit}, 3'b010);
      rst = 0;
      for (int n = 0; n < 7; n++) begin
         tick();
         rstEn[n] = o_cpuClkEn;
      end
      check("rst_no_press", rstEn[5:2], 4'b0000);
      check("rst_press", rstEn[6], 1);
      btn = 0; freeze = 0;
      ticks(10);

      // Randomized traffic against the model.
      randDp = 1;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom % 6 == 0) btn = ~btn;
         if ($urandom % 40 == 0) swI = ~swI;
         if ($urandom % 30 == 0) swS = ~swS;
         if ($urandom % 50 == 0) swB = ~swB;
         if ($urandom % 100 == 0) bpAddr = AW'($urandom % 4);
         rst = ($urandom % 300) == 0;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
